// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and width for the MIPS multiply/divide unit
package muldiv_pkg;
    localparam int WIDTH = 32;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;
    function automatic logic sgn_op(op_e o);
        return o == OP_MULT || o == OP_DIV;
    endfunction
    function automatic logic div_op(op_e o);
        return o == OP_DIV || o == OP_DIVU;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue, HI/LO move and status signals between control unit and multiply/divide unit
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::WIDTH);
    import muldiv_pkg::*;
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );
    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's complement used for operand magnitude and result sign fix
module muldiv_negate #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with private HI/LO, shift-add multiply and restoring divide
module muldiv_unit #(parameter int WIDTH = muldiv_pkg::WIDTH) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    import muldiv_pkg::*;
    state_e             state, nxt;
    op_e                op_q;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opb;
    logic               res_neg, rem_neg, dz;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               load, step, fin, idle, sgn;
    logic [WIDTH-1:0]   rs_abs, rt_abs, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     madd, dsh;
    logic [WIDTH-1:0]   rnew;
    logic               ge;
    assign sgn = sgn_op(bus.op);
    muldiv_negate #(.W(WIDTH)) u_rs_abs (.a(bus.rs_data), .neg(sgn & bus.rs_data[WIDTH-1]), .y(rs_abs));
    muldiv_negate #(.W(WIDTH)) u_rt_abs (.a(bus.rt_data), .neg(sgn & bus.rt_data[WIDTH-1]), .y(rt_abs));
    muldiv_negate #(.W(2*WIDTH)) u_prod (.a(acc), .neg(res_neg), .y(prod));
    muldiv_negate #(.W(WIDTH)) u_quo (.a(acc[WIDTH-1:0]), .neg(res_neg), .y(quo));
    muldiv_negate #(.W(WIDTH)) u_rem (.a(acc[2*WIDTH-1:WIDTH]), .neg(rem_neg), .y(rem));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = (state == IDLE) ? (bus.start ? CALC : IDLE) :
              (state == CALC) ? ((cnt == 6'(WIDTH-1)) ? FIX : CALC) : IDLE;
    end
    always_comb begin
        idle     = state == IDLE;
        load     = idle && bus.start;
        step     = state == CALC;
        fin      = state == FIX;
        bus.busy = !idle;
    end
    // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there and the remainder above it.
    always_comb begin
        madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        dsh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = dsh >= {1'b0, opb};
        rnew     = ge ? dsh[WIDTH-1:0] - opb : dsh[WIDTH-1:0];
        acc_step = div_op(op_q) ? {rnew, acc[WIDTH-2:0], ge} : {madd, acc[WIDTH-1:1]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_MULT;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz      <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                op_q    <= bus.op;
                cnt     <= '0;
                opb     <= div_op(bus.op) ? rt_abs : rs_abs;
                acc     <= {{WIDTH{1'b0}}, div_op(bus.op) ? rs_abs : rt_abs};
                res_neg <= sgn & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                rem_neg <= sgn & bus.rs_data[WIDTH-1];
                dz      <= div_op(bus.op) && bus.rt_data == '0;
            end
            if (step) begin
                acc <= acc_step;
                cnt <= cnt + 6'd1;
            end
            if (idle && bus.hi_we) hi_q <= bus.wdata;
            if (idle && bus.lo_we) lo_q <= bus.wdata;
            // A zero divisor leaves the dividend magnitude as remainder, so the sign fix restores raw rs in HI.
            if (fin) begin
                hi_q <= div_op(op_q) ? rem : prod[2*WIDTH-1:WIDTH];
                lo_q <= div_op(op_q) ? (dz ? '1 : quo) : prod[WIDTH-1:0];
            end
        end
    end
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit covering arithmetic, divide-by-zero, busy, back-to-back and reset abort
module tb_muldiv_unit;
    import muldiv_pkg::*;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last;
    muldiv_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        longint p, q, r;
        logic [63:0] u;
        e.dz = 1'b0;
        if (op == 2'b00) begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (op == 2'b01) begin
            u = {32'b0, a} * {32'b0, b};
            e.hi = u[63:32]; e.lo = u[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1; e.lo = 32'hFFFFFFFF; e.hi = a;
        end else if (op == 2'b10) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
            e.lo = a / b; e.hi = a % b;
        end
        return e;
    endfunction

    // Called at a negedge; start is seen by the following posedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op_e'(op); bus.rs_data = a; bus.rt_data = b;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        n_chk++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b exp 0", bus.div_zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [1:0]  op_t[6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        logic [31:0] a_t[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, $urandom, $urandom};
        logic [31:0] b_t[6]  = '{32'd2, 32'd2, 32'h80000000, 32'h9ABCDEF0, $urandom, $urandom};
        exp_t e;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            issue(op_t[i], a_t[i], b_t[i]);
            n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult%0d_busy got %b exp 1", i, bus.busy); end
            wait_done(cyc);
            n_chk++; if (cyc != 33) begin n_fail++; $display("FAIL mult%0d_latency got %0d exp 33", i, cyc); end
            e = sb.pop_front();
            last = e;
            n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL mult%0d_hi got %h exp %h", i, bus.hi, e.hi); end
            n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL mult%0d_lo got %h exp %h", i, bus.lo, e.lo); end
            n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult%0d_busy_end got %b exp 0", i, bus.busy); end
            @(negedge clk);
            n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult%0d_done_pulse got %b exp 0", i, bus.done); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  op_t[7] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [31:0] a_t[7]  = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFF9, $urandom, $urandom};
        logic [31:0] b_t[7]  = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, $urandom_range(1, 1000), $urandom};
        exp_t e;
        int cyc;
        for (int i = 0; i < 7; i++) begin
            issue(op_t[i], a_t[i], b_t[i]);
            wait_done(cyc);
            n_chk++; if (cyc != 33) begin n_fail++; $display("FAIL div%0d_latency got %0d exp 33", i, cyc); end
            e = sb.pop_front();
            last = e;
            n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL div%0d_lo got %h exp %h", i, bus.lo, e.lo); end
            n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL div%0d_hi got %h exp %h", i, bus.hi, e.hi); end
            n_chk++; if (bus.div_zero !== e.dz) begin n_fail++; $display("FAIL div%0d_dz got %b exp %b", i, bus.div_zero, e.dz); end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  op_t[3] = '{2'b11, 2'b10, 2'b01};
        logic [31:0] a_t[3]  = '{32'd100, 32'hFFFFFFFB, 32'd7};
        logic [31:0] b_t[3]  = '{32'd0, 32'd0, 32'd6};
        exp_t e;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue(op_t[i], a_t[i], b_t[i]);
            if (i == 2) begin
                n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start got %b exp 0", bus.div_zero); end
            end
            wait_done(cyc);
            n_chk++; if (cyc != 33) begin n_fail++; $display("FAIL dz%0d_latency got %0d exp 33", i, cyc); end
            e = sb.pop_front();
            last = e;
            n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL dz%0d_lo got %h exp %h", i, bus.lo, e.lo); end
            n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL dz%0d_hi got %h exp %h", i, bus.hi, e.hi); end
            n_chk++; if (bus.div_zero !== e.dz) begin n_fail++; $display("FAIL dz%0d_flag got %b exp %b", i, bus.div_zero, e.dz); end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int cyc;
        issue(2'b01, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_chk++; if (bus.hi !== last.hi) begin n_fail++; $display("FAIL busy_hi_hold got %h exp %h", bus.hi, last.hi); end
        n_chk++; if (bus.lo !== last.lo) begin n_fail++; $display("FAIL busy_lo_hold got %h exp %h", bus.lo, last.lo); end
        wait_done(cyc);
        n_chk++; if (cyc + 5 != 33) begin n_fail++; $display("FAIL busy_latency got %0d exp 33", cyc + 5); end
        e = sb.pop_front();
        last = e;
        n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL busy_hi got %h exp %h", bus.hi, e.hi); end
        n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL busy_lo got %h exp %h", bus.lo, e.lo); end
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart got %b exp 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op_t[3] = '{2'b00, 2'b11, 2'b10};
        logic [31:0] a_t[3]  = '{32'hFFFFFFFD, 32'd1000, 32'h7FFFFFFF};
        logic [31:0] b_t[3]  = '{32'd9, 32'd33, 32'hFFFFFFF0};
        exp_t e;
        int cyc;
        issue(op_t[0], a_t[0], b_t[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done(cyc);
            n_chk++; if (cyc != 33) begin n_fail++; $display("FAIL b2b%0d_latency got %0d exp 33", i, cyc); end
            e = sb.pop_front();
            last = e;
            n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL b2b%0d_hi got %h exp %h", i, bus.hi, e.hi); end
            n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL b2b%0d_lo got %h exp %h", i, bus.lo, e.lo); end
            if (i < 2) issue(op_t[i+1], a_t[i+1], b_t[i+1]);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        issue(2'b00, 32'h00012345, 32'h00054321);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi got %h exp 0", bus.hi); end
        n_chk++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo got %h exp 0", bus.lo); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", seen); end
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        n_chk++; if (bus.lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo got %h exp 00001234", bus.lo); end
        n_chk++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_hi got %h exp 0", bus.hi); end
        bus.hi_we = 1'b1; bus.wdata = 32'hABCD0000;
        @(negedge clk);
        bus.hi_we = 1'b0;
        n_chk++; if (bus.hi !== 32'hABCD0000) begin n_fail++; $display("FAIL mthi_hi got %h exp abcd0000", bus.hi); end
        n_chk++; if (bus.lo !== 32'h1234) begin n_fail++; $display("FAIL mthi_lo got %h exp 00001234", bus.lo); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        last = '{hi: 32'h0, lo: 32'h0, dz: 1'b0};
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
